// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Program-side responder for a single-cycle CPU's fetch port. A 256x8
//   program RAM is filled from a byte stream (length byte, program bytes,
//   checksum byte). The CPU is only released (cpu_run=1) once the image
//   checksum verifies, and only then does the fetch port return RAM data.
//
// Ports
//   clk          system clock, rising-edge active
//   reset        asynchronous active-high reset of all control state
//   read_address CPU fetch address (PC)
//   instruction  fetched byte; RAM[read_address] in RUN, IDLE_INSTR otherwise
//   cpu_run      1 while the verified image is executing
//   load_start   one-cycle pulse that (re)starts a load from any state
//   load_valid   load_data holds a stream byte this cycle
//   load_data    stream byte
//   load_ready   block accepts a byte when load_valid=1 (LEN/DATA/CHK)
//   load_done    one-cycle pulse when the image verifies
//   load_error   sticky flag: the last load failed its checksum
module instr_mem_loader #(
  parameter logic [7:0] IDLE_INSTR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] read_address,
  output logic [7:0] instruction,
  output logic       cpu_run,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       load_done,
  output logic       load_error
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ptr_q, ptr_d;
  logic [8:0] cnt_q, cnt_d;          // data bytes accepted so far
  logic [8:0] len_q, len_d;          // image length, 1..256
  logic [7:0] sum_q, sum_d;
  logic       cpu_run_q, cpu_run_d;
  logic       load_ready_q, load_ready_d;
  logic       load_done_q, load_done_d;
  logic       load_error_q, load_error_d;

  logic       accept_s;
  logic       mem_we_s;
  logic [7:0] chk_sum_s;
  logic [7:0] mem [0:255];

  // load_ready_q mirrors state_q exactly, so it doubles as the accept qualifier.
  assign accept_s  = load_valid & load_ready_q;
  assign chk_sum_s = sum_q + load_data;

  // Next-state, datapath and output computation for the load FSM.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    sum_d        = sum_q;
    load_done_d  = 1'b0;
    load_error_d = load_error_q;
    mem_we_s     = 1'b0;

    if (load_start) begin
      // load_start wins over any byte presented in the same cycle.
      state_d      = ST_LEN;
      ptr_d        = 8'd0;
      cnt_d        = 9'd0;
      sum_d        = 8'd0;
      load_error_d = 1'b0;
    end else if (accept_s) begin
      case (state_q)
        ST_LEN: begin
          // A length byte of zero encodes a full 256-byte image.
          len_d   = (load_data == 8'h00) ? 9'd256 : {1'b0, load_data};
          state_d = ST_DATA;
        end
        ST_DATA: begin
          mem_we_s = 1'b1;
          ptr_d    = ptr_q + 8'd1;   // wraps 255->0 on the last byte of a 256-byte image
          sum_d    = sum_q + load_data;
          cnt_d    = cnt_q + 9'd1;
          if ((cnt_q + 9'd1) == len_q) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_CHK: begin
          if (chk_sum_s == 8'h00) begin
            state_d      = ST_RUN;
            load_done_d  = 1'b1;
            load_error_d = 1'b0;
          end else begin
            state_d      = ST_ERR;
            load_error_d = 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    load_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHK);
    cpu_run_d    = (state_d == ST_RUN);
  end

  // Control-state and registered-output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 8'd0;
      cnt_q        <= 9'd0;
      len_q        <= 9'd0;
      sum_q        <= 8'd0;
      cpu_run_q    <= 1'b0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      sum_q        <= sum_d;
      cpu_run_q    <= cpu_run_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  // Program RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[ptr_q] <= load_data;
    end
  end

  // Zero-latency fetch for the single-cycle CPU, gated to the verified image.
  assign instruction = cpu_run_q ? mem[read_address] : IDLE_INSTR;
  assign cpu_run     = cpu_run_q;
  assign load_ready  = load_ready_q;
  assign load_done   = load_done_q;
  assign load_error  = load_error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  logic       clk;
  logic       reset;
  logic [7:0] read_address;
  logic [7:0] instruction;
  logic       cpu_run;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_done;
  logic       load_error;

  int n_checks;
  int n_errors;

  instr_mem_loader #(.IDLE_INSTR(8'h00)) dut (
    .clk          (clk),
    .reset        (reset),
    .read_address (read_address),
    .instruction  (instruction),
    .cpu_run      (cpu_run),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .load_done    (load_done),
    .load_error   (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_data  = b;
    tick();
    load_valid = 1'b0;
    load_data  = 8'hEE;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      load_data = 8'hEE;
      tick();
    end
  endtask

  task automatic check_fetch(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    read_address = addr;
    #1;
    check_value(tag, instruction, exp);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    read_address = 8'h00;
    load_start   = 1'b0;
    load_valid   = 1'b0;
    load_data    = 8'h00;
    #22;
    check_value("rst_cpu_run",    {7'd0, cpu_run},    8'h00);
    check_value("rst_load_ready", {7'd0, load_ready}, 8'h00);
    check_value("rst_load_done",  {7'd0, load_done},  8'h00);
    check_value("rst_load_error", {7'd0, load_error}, 8'h00);
    check_value("rst_instr",      instruction,        8'h00);
    reset = 1'b0;
    tick();

    // 1) good 3-byte image: 41+12+80 = D3, D3+2D = 00
    pulse_start();
    check_value("t1_ready", {7'd0, load_ready}, 8'h01);
    send_byte(8'h03);
    send_byte(8'h41);
    send_byte(8'h12);
    send_byte(8'h80);
    check_value("t1_run_before_chk", {7'd0, cpu_run}, 8'h00);
    send_byte(8'h2D);
    check_value("t1_done",   {7'd0, load_done},  8'h01);
    check_value("t1_run",    {7'd0, cpu_run},    8'h01);
    check_value("t1_err",    {7'd0, load_error}, 8'h00);
    check_value("t1_ready0", {7'd0, load_ready}, 8'h00);
    check_fetch("t1_i0", 8'h00, 8'h41);
    check_fetch("t1_i1", 8'h01, 8'h12);
    check_fetch("t1_i2", 8'h02, 8'h80);
    tick();
    check_value("t1_done_pulse", {7'd0, load_done}, 8'h00);
    check_value("t1_run_hold",   {7'd0, cpu_run},   8'h01);

    // 2) bad checksum: D3+2C = FF
    pulse_start();
    check_value("t2_run_drop", {7'd0, cpu_run}, 8'h00);
    send_byte(8'h03);
    send_byte(8'h41);
    send_byte(8'h12);
    send_byte(8'h80);
    send_byte(8'h2C);
    check_value("t2_err",   {7'd0, load_error}, 8'h01);
    check_value("t2_run",   {7'd0, cpu_run},    8'h00);
    check_value("t2_done",  {7'd0, load_done},  8'h00);
    check_fetch("t2_i0", 8'h00, 8'h00);
    check_fetch("t2_i2", 8'h02, 8'h00);
    send_byte(8'h55);
    send_byte(8'hAB);
    check_value("t2_err_sticky", {7'd0, load_error}, 8'h01);
    check_value("t2_ready0",     {7'd0, load_ready}, 8'h00);
    check_value("t2_run_stays0", {7'd0, cpu_run},    8'h00);

    // 3) 256-byte image, value = address; sum 0..255 = 7F80 -> 80, checksum 80
    pulse_start();
    check_value("t3_err_clr", {7'd0, load_error}, 8'h00);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i));
    end
    check_value("t3_in_chk", {7'd0, load_ready}, 8'h01);
    send_byte(8'h80);
    check_value("t3_done", {7'd0, load_done}, 8'h01);
    check_value("t3_run",  {7'd0, cpu_run},   8'h01);
    check_fetch("t3_iFF", 8'hFF, 8'hFF);
    check_fetch("t3_i00", 8'h00, 8'h00);
    check_fetch("t3_i7A", 8'h7A, 8'h7A);

    // 4) load_start with a byte in the same cycle: 05 is ignored
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h05;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    check_value("t4_run_drop", {7'd0, cpu_run},    8'h00);
    check_value("t4_ready",    {7'd0, load_ready}, 8'h01);
    send_byte(8'h02);
    send_byte(8'hA5);
    send_byte(8'h5B);
    send_byte(8'h00);
    check_value("t4_done", {7'd0, load_done}, 8'h01);
    check_fetch("t4_i0", 8'h00, 8'hA5);
    check_fetch("t4_i1", 8'h01, 8'h5B);
    check_fetch("t4_i2", 8'h02, 8'h02);
    check_fetch("t4_i3", 8'h03, 8'h03);

    // 5) reset after two DATA bytes of a four-byte load
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    #2;
    check_value("t5_run",   {7'd0, cpu_run},    8'h00);
    check_value("t5_ready", {7'd0, load_ready}, 8'h00);
    check_value("t5_done",  {7'd0, load_done},  8'h00);
    check_value("t5_err",   {7'd0, load_error}, 8'h00);
    check_value("t5_instr", instruction,        8'h00);
    tick();
    reset = 1'b0;
    send_byte(8'h33);
    check_value("t5_idle_ready", {7'd0, load_ready}, 8'h00);

    // 6) 1-byte image C0 (C0+40 = 00); other locations keep earlier data
    pulse_start();
    send_byte(8'h01);
    send_byte(8'hC0);
    send_byte(8'h40);
    check_value("t6_done", {7'd0, load_done}, 8'h01);
    check_fetch("t6_i0", 8'h00, 8'hC0);
    check_fetch("t6_i1", 8'h01, 8'h22);
    check_fetch("t6_i2", 8'h02, 8'h02);
    check_fetch("t6_i3", 8'h03, 8'h03);

    // 7) gaps of 3 idle cycles between accepted beats: 10+20+D0 = 00
    pulse_start();
    idle_cycles(3);
    send_byte(8'h02);
    idle_cycles(3);
    send_byte(8'h10);
    idle_cycles(3);
    check_value("t7_gap_ready", {7'd0, load_ready}, 8'h01);
    send_byte(8'h20);
    idle_cycles(3);
    check_value("t7_gap_done", {7'd0, load_done}, 8'h00);
    send_byte(8'hD0);
    check_value("t7_done", {7'd0, load_done}, 8'h01);
    check_value("t7_run",  {7'd0, cpu_run},   8'h01);
    check_fetch("t7_i0", 8'h00, 8'h10);
    check_fetch("t7_i1", 8'h01, 8'h20);
    check_fetch("t7_i2", 8'h02, 8'h02);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
